subtree_rr_arbiter: RTL and testbench

SUBTREE_RR_ARBITER -- requirements
Module: subtree_rr_arbiter

---
 rtl/subtree_arb_pkg.sv | 23 ++
 rtl/subtree_rr_arbiter_rr_pick.sv | 36 +++
 rtl/subtree_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_subtree_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/subtree_arb_pkg.sv
// Shared definitions for the subtree round-robin arbiter.
//   arb_state_e   : arbiter FSM state encoding
//   NUM_REQ_DEF   : default number of sibling requesters
//   HOLD_MAX_DEF  : default maximum grant hold time in cycles
//   wrap_add()    : modular add used by the rotating priority scan
package subtree_arb_pkg;

    localparam int NUM_REQ_DEF  = 10;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/subtree_rr_arbiter_rr_pick.sv
// Rotating-priority selector (purely combinational).
//   req_i    : request vector
//   ptr_i    : index with highest priority this round
//   onehot_o : one-hot of the first set request at or above ptr_i (wrapping)
//   idx_o    : index of that request; 0 when req_i is all zero
module rr_pick
    import subtree_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic found;
    int   k;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        k        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = wrap_add(int'(ptr_i), i, NUM_REQ);
            if (!found && req_i[IDX_W'(k)]) begin
                found                 = 1'b1;
                onehot_o[IDX_W'(k)]   = 1'b1;
                idx_o                 = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/subtree_rr_arbiter.sv
// Round-robin arbiter sharing one resource among sibling sub-instances.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : level request per requester
//   rel       : release strobe per requester (only the owner's bit matters)
//   gnt       : registered one-hot grant (or zero)
//   gnt_valid : OR of gnt
//   gnt_idx   : owner index, 0 when no grant
//   timeout   : one-cycle pulse when the owner is revoked after HOLD_MAX cycles
//   grant_cnt : saturating count of grants issued
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner, arbitrate on any request
// ST_OWN  | grant held by idx_q, hold counter running
// ST_GAP  | one dead cycle after an owner leaves, then arbitrate
module subtree_rr_arbiter
    import subtree_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               timeout,
    output logic [15:0]        grant_cnt
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          grant_cnt_q, grant_cnt_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 owner_leaves;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // Owner gives up either by strobing rel or by dropping its request.
    assign owner_leaves = rel[idx_q] | ~req[idx_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        timeout_d   = 1'b0;
        grant_cnt_d = grant_cnt_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (|req) begin
                    state_d = ST_OWN;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    hold_d  = HOLD_W'(1);
                    if (grant_cnt_q != 16'hFFFF)
                        grant_cnt_d = grant_cnt_q + 16'd1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (owner_leaves || hold_q == HOLD_W'(HOLD_MAX)) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    idx_d     = '0;
                    hold_d    = '0;
                    ptr_d     = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    // A release in the same cycle as expiry is a normal exit.
                    timeout_d = ~owner_leaves;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            timeout_q   <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            timeout_q   <= timeout_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
module tb_subtree_rr_arbiter;

    localparam int N = 10;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [3:0]   gnt_idx;
    logic         timeout;
    logic [15:0]  grant_cnt;

    int checks;
    int passes;
    int exp_q[$];
    logic [N-1:0] prev_gnt;
    logic         prev_valid;

    subtree_rr_arbiter #(.NUM_REQ(N), .HOLD_MAX(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard: every new grant pops the expected owner index.
    always @(negedge clk) begin
        if (rst_n && gnt_valid && (!prev_valid || gnt != prev_gnt)) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: gnt=%b with no expected grant", gnt);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (gnt !== bit_of(e) || gnt_idx !== 4'(e))
                    $display("FAIL sb_grant: gnt=%b idx=%0d expected gnt=%b idx=%0d",
                             gnt, gnt_idx, bit_of(e), e);
                else
                    passes++;
            end
        end
        if ($countones(gnt) > 1) begin
            checks++;
            $display("FAIL onehot: gnt=%b has more than one bit", gnt);
        end
        prev_gnt   = gnt;
        prev_valid = gnt_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passes++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        rel   = '0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        chk("reset_idx", 32'(gnt_idx), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        chk("reset_cnt", 32'(grant_cnt), 32'h0);
    endtask

    task automatic test_single();
        tick(3);
        req = 10'b0000001000;
        exp_q.push_back(3);
        tick(1);
        chk("single_gnt", 32'(gnt), 32'h008);
        chk("single_idx", 32'(gnt_idx), 32'd3);
        chk("single_valid", 32'(gnt_valid), 32'd1);
        chk("single_cnt", 32'(grant_cnt), 32'd1);
        req = '0;
        tick(1);
        chk("single_drop", 32'(gnt), 32'h0);
        chk("single_idx0", 32'(gnt_idx), 32'h0);
        tick(1);
    endtask

    task automatic test_rotation();
        do_reset();
        req = '1;
        for (int k = 0; k < 11; k++) exp_q.push_back(k % N);
        for (int k = 0; k < 11; k++) begin
            tick(1);
            chk("rot_gnt", 32'(gnt), 32'(bit_of(k % N)));
            tick(1);
            chk("rot_hold", 32'(gnt), 32'(bit_of(k % N)));
            rel = bit_of(k % N);
            tick(1);
            rel = '0;
            chk("rot_gap", 32'(gnt), 32'h0);
            if (k == 10) req = '0;
        end
        chk("rot_cnt", 32'(grant_cnt), 32'd11);
        tick(2);
    endtask

    task automatic test_timeout();
        do_reset();
        req = bit_of(4);
        exp_q.push_back(4);
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            chk("to_hold_gnt", 32'(gnt), 32'(bit_of(4)));
            chk("to_hold_pulse", 32'(timeout), 32'h0);
        end
        exp_q.push_back(4);
        tick(1);
        chk("to_clear_gnt", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        tick(1);
        chk("to_regrant", 32'(gnt), 32'(bit_of(4)));
        chk("to_pulse_once", 32'(timeout), 32'h0);
        req = '0;
        tick(2);
    endtask

    task automatic test_rel_at_max();
        req = bit_of(4);
        exp_q.push_back(4);
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            chk("rm_hold_gnt", 32'(gnt), 32'(bit_of(4)));
        end
        rel = bit_of(4);
        tick(1);
        chk("rm_clear_gnt", 32'(gnt), 32'h0);
        chk("rm_no_timeout", 32'(timeout), 32'h0);
        rel = '0;
        req = '0;
        tick(2);
    endtask

    task automatic test_wrap();
        do_reset();
        req = bit_of(9);
        exp_q.push_back(9);
        tick(1);
        chk("wrap_own9", 32'(gnt), 32'(bit_of(9)));
        req = bit_of(9) | bit_of(0);
        rel = bit_of(0);
        tick(1);
        chk("wrap_nonowner_rel", 32'(gnt), 32'(bit_of(9)));
        rel = bit_of(9);
        exp_q.push_back(0);
        tick(1);
        rel = '0;
        chk("wrap_gap", 32'(gnt), 32'h0);
        tick(1);
        chk("wrap_gnt0", 32'(gnt), 32'(bit_of(0)));
        chk("wrap_idx0", 32'(gnt_idx), 32'h0);
        chk("wrap_valid", 32'(gnt_valid), 32'h1);
        req = '0;
        tick(2);
    endtask

    task automatic test_reset_mid_own();
        req = bit_of(2);
        exp_q.push_back(2);
        tick(3);
        chk("rmo_own", 32'(gnt), 32'(bit_of(2)));
        rst_n = 1'b0;
        tick(1);
        chk("rmo_gnt", 32'(gnt), 32'h0);
        chk("rmo_valid", 32'(gnt_valid), 32'h0);
        chk("rmo_idx", 32'(gnt_idx), 32'h0);
        chk("rmo_timeout", 32'(timeout), 32'h0);
        chk("rmo_cnt", 32'(grant_cnt), 32'h0);
        req   = '0;
        rst_n = 1'b1;
        tick(1);
        chk("rmo_after_timeout", 32'(timeout), 32'h0);
    endtask

    task automatic test_saturation();
        logic [15:0] exp_cnt;
        force dut.grant_cnt_q = 16'hFFFE;
        tick(1);
        release dut.grant_cnt_q;
        tick(1);
        chk("sat_preload", 32'(grant_cnt), 32'hFFFE);
        exp_cnt = 16'hFFFE;
        for (int g = 0; g < 3; g++) begin
            req = bit_of(1);
            exp_q.push_back(1);
            tick(1);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            chk("sat_cnt", 32'(grant_cnt), 32'(exp_cnt));
            req = '0;
            tick(2);
        end
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        prev_gnt   = '0;
        prev_valid = 1'b0;
        rst_n      = 1'b0;
        req        = '0;
        rel        = '0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_rel_at_max();
        test_wrap();
        test_reset_mid_own();
        test_saturation();
        tick(2);
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d expected grants never seen", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
